// File: rtl/axis_s_fifo.sv
// AXI-Stream slave terminating a single-beat master into a first-word-fall-through FIFO.
// Define AXIS_S_PKT_CNT_EN to add a 16-bit count of accepted tlast beats (pkt_cnt).
module axis_s_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W:0]   level
`ifdef AXIS_S_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W:0] mem [DEPTH];
    logic [DATA_W:0] head;
    logic            full;
    logic            empty;
    logic            wr_en;
    logic            rd_en;

    // Flags come only from registered pointers so s_tready never loops through tvalid.
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign s_tready = !full;
    assign rd_valid = !empty;
    assign wr_en    = s_tvalid && !full;
    assign rd_en    = rd_ready && !empty;
    assign level    = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {s_tlast, s_tdata};
        end
    end

    // Head slot is never written while occupied, so the read port is stable under backpressure.
    assign head    = mem[rd_ptr_q[ADDR_W-1:0]];
    assign rd_data = empty ? '0 : head[DATA_W-1:0];
    assign rd_last = empty ? 1'b0 : head[DATA_W];

`ifdef AXIS_S_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (wr_en && s_tlast) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_s_fifo.sv
// Directed plus randomized check of axis_s_fifo against a queue-based model of the stream buffer.
module tb_axis_s_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic [AW:0]   level;
`ifdef AXIS_S_PKT_CNT_EN
    logic [15:0]   pkt_cnt;
`endif

    axis_s_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .aclk     (aclk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .level    (level)
`ifdef AXIS_S_PKT_CNT_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t       model_q[$];
    logic [15:0] exp_pkt;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model's current occupancy and head.
    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".s_tready"}, 64'(s_tready), 64'(sz < DEPTH));
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(sz > 0));
        chk({tag, ".level"}, 64'(level), 64'(sz));
        chk({tag, ".rd_data"}, 64'(rd_data), (sz > 0) ? 64'(model_q[0].data) : 64'd0);
        chk({tag, ".rd_last"}, 64'(rd_last), (sz > 0) ? 64'(model_q[0].last) : 64'd0);
`ifdef AXIS_S_PKT_CNT_EN
        chk({tag, ".pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
`endif
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model across the rising edge.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic l,
                         input logic rr, input logic r, output logic hs);
        logic wr;
        logic rd;
        beat_t b;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        rd_ready = rr;
        rst      = r;
        #1;
        check_state(tag);
        wr = v && (model_q.size() < DEPTH);
        rd = rr && (model_q.size() > 0);
        hs = wr && !r;
        @(posedge aclk);
        if (r) begin
            model_q.delete();
            exp_pkt = '0;
        end else begin
            if (rd) begin
                b = model_q.pop_front();
            end
            if (wr) begin
                b.last = l;
                b.data = d;
                model_q.push_back(b);
                if (l) begin
                    exp_pkt = exp_pkt + 16'd1;
                end
            end
        end
        @(negedge aclk);
        $display("%0t %s v=%0b d=%08h l=%0b rr=%0b rst=%0b -> level=%0d head=%08h", $time, tag, v, d, l,
                 rr, r, level, rd_data);
    endtask

    initial begin
        logic hs;
        logic finish;
        int   hs_cnt;
        n_assert = 0;
        n_fail   = 0;
        exp_pkt  = '0;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        rd_ready = 1'b0;
        @(negedge aclk);
        cycle("reset", 1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b1, hs);
        cycle("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, hs);

        // Single beat with tlast, consumer stalled, then popped.
        cycle("single", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, hs);
        cycle("single_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, hs);
        chk("single.level1", 64'(level), 64'd1);
        chk("single.data", 64'(rd_data), 64'hDEAD_BEEF);
        cycle("single_pop", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, hs);
        cycle("empty_rr", 1'b0, 32'h5, 1'b1, 1'b1, 1'b0, hs);

        // Fill to full, then a pending 17th beat must not be stored.
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fill", 1'b1, 32'(i), 1'(i == DEPTH - 1), 1'b0, 1'b0, hs);
        end
        chk("fill.full_level", 64'(level), 64'(DEPTH));
        chk("fill.tready_low", 64'(s_tready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle("pending", 1'b1, 32'd16, 1'b0, 1'b0, 1'b0, hs);
            chk("pending.no_hs", 64'(hs), 64'd0);
        end
        cycle("drain_full", 1'b1, 32'd16, 1'b0, 1'b1, 1'b0, hs);
        chk("drain_full.tready", 64'(s_tready), 64'd1);
        cycle("accept_pending", 1'b1, 32'd16, 1'b0, 1'b0, 1'b0, hs);
        chk("accept_pending.hs", 64'(hs), 64'd1);
        chk("refull.level", 64'(level), 64'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle("drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, hs);
        end

        // Continuous streaming across several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            cycle("stream", 1'b1, 32'(i), 1'b0, 1'b1, 1'b0, hs);
            chk("stream.hs", 64'(hs), 64'd1);
            chk("stream.level_le1", 64'(level <= 1), 64'd1);
        end
        cycle("stream_tail", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, hs);

        // Reset with five beats stored flushes them.
        for (int i = 0; i < 5; i++) begin
            cycle("pre_rst", 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, hs);
        end
        chk("pre_rst.level5", 64'(level), 64'd5);
        cycle("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, hs);
        chk("mid_rst.level0", 64'(level), 64'd0);
        cycle("post_rst", 1'b1, 32'hC0FF_EE00, 1'b1, 1'b0, 1'b0, hs);
        chk("post_rst.head", 64'(rd_data), 64'hC0FF_EE00);
        cycle("post_rst_pop", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, hs);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0), hs);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle("rand_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, hs);
        end

        // Single-beat master: hold tvalid until accepted, then raise finish; bounded wait.
        finish = 1'b0;
        hs_cnt = 0;
        for (int i = 0; i < 20 && !finish; i++) begin
            cycle("master", 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, hs);
            if (hs) begin
                hs_cnt++;
                finish = 1'b1;
            end
        end
        cycle("master_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, hs);
        chk("master.finish", 64'(finish), 64'd1);
        chk("master.hs_count", 64'(hs_cnt), 64'd1);
        chk("master.data", 64'(rd_data), 64'h1234_5678);
        chk("master.last", 64'(rd_last), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
